// File: rtl/ex_stage_if.sv
// Handshake and result-record bus between the register-file stage, ex_stage and
// memory/writeback. The stage uses the slave view; the upstream/downstream environment uses master.
interface ex_stage_if;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [31:0] IR_i;
   logic [31:0] pc_i;
   logic [31:0] data1_i;
   logic [31:0] data2_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] result_o;
   logic [31:0] store_o;
   logic [5:0]  writenum_o;
   logic        mem_rd_o;
   logic        mem_wr_o;
   logic        br_taken_o;
   logic [31:0] br_target_o;

   modport slave (
      input  in_valid_i, IR_i, pc_i, data1_i, data2_i, out_ready_i,
      output in_ready_o, out_valid_o, result_o, store_o, writenum_o,
             mem_rd_o, mem_wr_o, br_taken_o, br_target_o
   );

   modport master (
      output in_valid_i, IR_i, pc_i, data1_i, data2_i, out_ready_i,
      input  in_ready_o, out_valid_o, result_o, store_o, writenum_o,
             mem_rd_o, mem_wr_o, br_taken_o, br_target_o
   );
endinterface

// File: rtl/ex_stage.sv
// MS108 execute stage: single-cycle ALU/shift/compare/address ops plus a
// shift-add multiplier, emitting one held result record per accepted instruction.
module ex_stage #(
   parameter int MUL_CYCLES = 32
) (
   input  logic      clk_i,
   input  logic      rst_n_i,
   ex_stage_if.slave bus
);
   localparam int            CW        = $clog2(MUL_CYCLES + 1);
   localparam logic [CW-1:0] LAST_ITER = CW'(MUL_CYCLES - 1);

   localparam logic [3:0] OP_LW    = 4'h0;
   localparam logic [3:0] OP_SW    = 4'h1;
   localparam logic [3:0] OP_LI    = 4'h2;
   localparam logic [3:0] OP_ADDU  = 4'h3;
   localparam logic [3:0] OP_ADDIU = 4'h4;
   localparam logic [3:0] OP_SLL   = 4'h5;
   localparam logic [3:0] OP_MUL   = 4'h6;
   localparam logic [3:0] OP_BGE   = 4'h7;
   localparam logic [3:0] OP_J     = 4'h8;
   localparam logic [3:0] OP_MULI  = 4'h9;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_OUT  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   acc_q, acc_d;
   logic [31:0]   mcand_q, mcand_d;
   logic [31:0]   mplier_q, mplier_d;
   logic          out_valid_q, out_valid_d;
   logic [31:0]   result_q, result_d;
   logic [31:0]   store_q, store_d;
   logic [5:0]    wn_q, wn_d;
   logic          mem_rd_q, mem_rd_d;
   logic          mem_wr_q, mem_wr_d;
   logic          br_taken_q, br_taken_d;
   logic [31:0]   br_target_q, br_target_d;

   logic          in_ready_s;
   logic          accept_s;
   logic [3:0]    op_s;
   logic [4:0]    ra_s;
   logic [31:0]   sx18_s;
   logic [31:0]   acc_sum_s;

   assign op_s       = bus.IR_i[31:28];
   assign ra_s       = bus.IR_i[27:23];
   assign sx18_s     = {{14{bus.IR_i[17]}}, bus.IR_i[17:0]};
   assign acc_sum_s  = acc_q + (mplier_q[0] ? mcand_q : 32'd0);
   // Ready is held low during reset so every output reads 0 while rst_n_i is asserted.
   assign in_ready_s = rst_n_i && ((state_q == ST_IDLE) || ((state_q == ST_OUT) && bus.out_ready_i));
   assign accept_s   = bus.in_valid_i && in_ready_s;

   // Next-state: multiplier iteration, record hand-off, then decode of an accepted instruction.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      store_d     = store_q;
      wn_d        = wn_q;
      mem_rd_d    = mem_rd_q;
      mem_wr_d    = mem_wr_q;
      br_taken_d  = 1'b0;
      br_target_d = br_target_q;
      case (state_q)
         ST_MUL: begin
            acc_d    = acc_sum_s;
            mcand_d  = {mcand_q[30:0], 1'b0};
            mplier_d = {1'b0, mplier_q[31:1]};
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST_ITER) begin
               state_d     = ST_OUT;
               out_valid_d = 1'b1;
               result_d    = acc_sum_s;
            end else begin
               state_d = ST_MUL;
            end
         end
         ST_OUT: begin
            if (bus.out_ready_i) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
            end else begin
               state_d = ST_OUT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (accept_s) begin
         state_d     = ST_OUT;
         out_valid_d = 1'b1;
         result_d    = 32'd0;
         store_d     = 32'd0;
         wn_d        = 6'd0;
         mem_rd_d    = 1'b0;
         mem_wr_d    = 1'b0;
         br_target_d = 32'd0;
         case (op_s)
            OP_LW: begin
               result_d = bus.data1_i + sx18_s;
               mem_rd_d = 1'b1;
               wn_d     = {1'b1, ra_s};
            end
            OP_SW: begin
               result_d = bus.data1_i + sx18_s;
               store_d  = bus.data2_i;
               mem_wr_d = 1'b1;
            end
            OP_LI: begin
               result_d = {{9{bus.IR_i[22]}}, bus.IR_i[22:0]};
               wn_d     = {1'b1, ra_s};
            end
            OP_ADDU: begin
               result_d = bus.data1_i + bus.data2_i;
               wn_d     = {1'b1, ra_s};
            end
            OP_ADDIU: begin
               result_d = bus.data1_i + sx18_s;
               wn_d     = {1'b1, ra_s};
            end
            OP_SLL: begin
               result_d = bus.data1_i << bus.IR_i[4:0];
               wn_d     = {1'b1, ra_s};
            end
            OP_MUL, OP_MULI: begin
               state_d     = ST_MUL;
               out_valid_d = 1'b0;
               wn_d        = {1'b1, ra_s};
               acc_d       = 32'd0;
               cnt_d       = {CW{1'b0}};
               mcand_d     = bus.data1_i;
               mplier_d    = (op_s == OP_MUL) ? bus.data2_i : sx18_s;
            end
            OP_BGE: begin
               if ($signed(bus.data1_i) >= $signed(bus.data2_i)) begin
                  br_taken_d  = 1'b1;
                  br_target_d = bus.pc_i + sx18_s;
               end else begin
                  br_taken_d  = 1'b0;
               end
            end
            OP_J: begin
               br_taken_d  = 1'b1;
               br_target_d = {bus.pc_i[31:28], bus.IR_i[27:0]};
            end
            default: begin
               result_d = 32'd0;
            end
         endcase
      end else begin
         br_taken_d = 1'b0;
      end
   end

   // State, multiplier datapath and registered record outputs.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= ST_IDLE;
         cnt_q       <= {CW{1'b0}};
         acc_q       <= 32'd0;
         mcand_q     <= 32'd0;
         mplier_q    <= 32'd0;
         out_valid_q <= 1'b0;
         result_q    <= 32'd0;
         store_q     <= 32'd0;
         wn_q        <= 6'd0;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         br_taken_q  <= 1'b0;
         br_target_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         store_q     <= store_d;
         wn_q        <= wn_d;
         mem_rd_q    <= mem_rd_d;
         mem_wr_q    <= mem_wr_d;
         br_taken_q  <= br_taken_d;
         br_target_q <= br_target_d;
      end
   end

   assign bus.in_ready_o  = in_ready_s;
   assign bus.out_valid_o = out_valid_q;
   assign bus.result_o    = result_q;
   assign bus.store_o     = store_q;
   assign bus.writenum_o  = wn_q;
   assign bus.mem_rd_o    = mem_rd_q;
   assign bus.mem_wr_o    = mem_wr_q;
   assign bus.br_taken_o  = br_taken_q;
   assign bus.br_target_o = br_target_q;
endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed instructions, a cycle-level reference model of the
// record/handshake timing, and hand-computed expectations pinning that model.
module tb_ex_stage;
   localparam int MUL_LAT = 33;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   ex_stage_if bus();

   ex_stage #(.MUL_CYCLES(32)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [31:0] result;
      logic [31:0] store;
      logic [5:0]  wn;
      logic        rd;
      logic        wr;
      logic        taken;
      logic [31:0] target;
      logic        is_mul;
   } rec_t;

   task automatic chk_b(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic chk_w(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] enc(input logic [3:0] op, input logic [4:0] ra,
                                       input logic [4:0] rs, input logic [17:0] imm);
      return {op, ra, rs, imm};
   endfunction

   // What the record must contain, straight from the opcode table.
   function automatic rec_t model(input logic [31:0] ir, input logic [31:0] pc,
                                  input logic [31:0] d1, input logic [31:0] d2);
      rec_t        r;
      logic [31:0] sx;
      logic [5:0]  dst;
      r   = '0;
      sx  = {{14{ir[17]}}, ir[17:0]};
      dst = {1'b1, ir[27:23]};
      case (ir[31:28])
         4'd0: begin r.result = d1 + sx; r.rd = 1'b1; r.wn = dst; end
         4'd1: begin r.result = d1 + sx; r.store = d2; r.wr = 1'b1; end
         4'd2: begin r.result = {{9{ir[22]}}, ir[22:0]}; r.wn = dst; end
         4'd3: begin r.result = d1 + d2; r.wn = dst; end
         4'd4: begin r.result = d1 + sx; r.wn = dst; end
         4'd5: begin r.result = d1 << ir[4:0]; r.wn = dst; end
         4'd6: begin r.result = d1 * d2; r.wn = dst; r.is_mul = 1'b1; end
         4'd9: begin r.result = d1 * sx; r.wn = dst; r.is_mul = 1'b1; end
         4'd7: begin r.taken = ($signed(d1) >= $signed(d2)); r.target = pc + sx; end
         4'd8: begin r.taken = 1'b1; r.target = {pc[31:28], ir[27:0]}; end
         default: begin r = '0; end
      endcase
      return r;
   endfunction

   rec_t cur;
   logic have_rec = 1'b0;
   int   vis_cyc  = 0;

   // Per-cycle comparison against the model; outputs are sampled on the falling edge.
   always @(negedge clk) begin : compare
      logic ov_e, ir_e, bt_e;
      if (!rst_n) begin
         have_rec = 1'b0;
         chk_w("reset_outputs",
               128'({bus.out_valid_o, bus.in_ready_o, bus.result_o, bus.store_o, bus.writenum_o,
                     bus.mem_rd_o, bus.mem_wr_o, bus.br_taken_o, bus.br_target_o}), 128'd0);
      end else begin
         ov_e = have_rec && (cyc >= vis_cyc);
         ir_e = !have_rec || (ov_e && bus.out_ready_i);
         bt_e = ov_e && cur.taken && (cyc == vis_cyc);
         chk_b("out_valid", bus.out_valid_o, ov_e);
         chk_b("in_ready", bus.in_ready_o, ir_e);
         chk_b("br_taken", bus.br_taken_o, bt_e);
         if (bt_e) chk_w("br_target", 128'(bus.br_target_o), 128'(cur.target));
         if (ov_e)
            chk_w("record",
                  128'({bus.result_o, bus.store_o, bus.writenum_o, bus.mem_rd_o, bus.mem_wr_o}),
                  128'({cur.result, cur.store, cur.wn, cur.rd, cur.wr}));
         if (ov_e && bus.out_ready_i) have_rec = 1'b0;
         if (bus.in_valid_i && ir_e) begin
            cur      = model(bus.IR_i, bus.pc_i, bus.data1_i, bus.data2_i);
            have_rec = 1'b1;
            vis_cyc  = cyc + (cur.is_mul ? MUL_LAT : 1);
         end
      end
   end

   task automatic drive(input logic [31:0] ir, input logic [31:0] pc,
                        input logic [31:0] d1, input logic [31:0] d2);
      bus.in_valid_i = 1'b1;
      bus.IR_i       = ir;
      bus.pc_i       = pc;
      bus.data1_i    = d1;
      bus.data2_i    = d2;
   endtask

   // Returns just after the accepting edge, with in_valid dropped.
   task automatic wait_accept();
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready_o) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: in_ready_o still 0 after %0d cycles, expected 1", n);
      end
      @(posedge clk);
      #1;
      bus.in_valid_i = 1'b0;
   endtask

   task automatic issue(input logic [31:0] ir, input logic [31:0] pc,
                        input logic [31:0] d1, input logic [31:0] d2);
      drive(ir, pc, d1, d2);
      wait_accept();
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.in_valid_i  = 1'b0;
      bus.IR_i        = 32'd0;
      bus.pc_i        = 32'd0;
      bus.data1_i     = 32'd0;
      bus.data2_i     = 32'd0;
      bus.out_ready_i = 1'b1;

      repeat (3) @(negedge clk);
      chk_b("rst_in_ready", bus.in_ready_o, 1'b0);
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk_b("post_rst_in_ready", bus.in_ready_o, 1'b1);
      step();

      // ADDU wraps: 0xFFFFFFFF + 2 = 1
      issue(enc(4'h3, 5'd5, 5'd1, 18'd0), 32'd0, 32'hFFFF_FFFF, 32'd2);
      @(negedge clk);
      chk_b("addu_valid_t1", bus.out_valid_o, 1'b1);
      chk_w("addu_result", 128'(bus.result_o), 128'(32'd1));
      chk_w("addu_writenum", 128'(bus.writenum_o), 128'(6'h25));
      step();

      issue(enc(4'h4, 5'd3, 5'd1, 18'h3FFFF), 32'd0, 32'd10, 32'd0);
      @(negedge clk);
      chk_w("addiu_result", 128'(bus.result_o), 128'(32'd9));
      step();

      issue(enc(4'h0, 5'd7, 5'd2, 18'd4), 32'd0, 32'h100, 32'd0);
      @(negedge clk);
      chk_w("lw_record", 128'({bus.result_o, bus.mem_rd_o, bus.writenum_o}),
            128'({32'h104, 1'b1, 6'h27}));
      step();

      // MUL 7 * -3, then a second MUL accepted as the first record leaves
      issue(enc(4'h6, 5'd9, 5'd1, 18'd0), 32'd0, 32'd7, 32'hFFFF_FFFD);
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         chk_b("mul_busy_in_ready", bus.in_ready_o, 1'b0);
         chk_b("mul_busy_out_valid", bus.out_valid_o, 1'b0);
         step();
      end
      drive(enc(4'h6, 5'd10, 5'd1, 18'd0), 32'd0, 32'h0001_0001, 32'h0001_0001);
      @(negedge clk);
      chk_b("mul_valid_t33", bus.out_valid_o, 1'b1);
      chk_w("mul_result", 128'({bus.result_o, bus.writenum_o}), 128'({32'hFFFF_FFEB, 6'h29}));
      chk_b("mul_in_ready_t33", bus.in_ready_o, 1'b1);
      step();
      bus.in_valid_i = 1'b0;
      repeat (31) @(posedge clk);
      #1;
      @(negedge clk);
      chk_b("mul2_not_yet", bus.out_valid_o, 1'b0);
      step();
      @(negedge clk);
      chk_w("mul2_result", 128'({bus.out_valid_o, bus.result_o}), 128'({1'b1, 32'h0002_0001}));
      step();

      issue(enc(4'h9, 5'd11, 5'd1, 18'h3FFFE), 32'd0, 32'd3, 32'd0);
      repeat (36) step();

      // Back-to-back single-cycle ops: SW, LI, SLL, NOP, ADDIU
      issue(enc(4'h1, 5'd4, 5'd2, 18'h00010), 32'd0, 32'h200, 32'hDEAD_BEEF);
      issue({4'h2, 5'd6, 23'h40_0005}, 32'd0, 32'd0, 32'd0);
      issue(enc(4'h5, 5'd8, 5'd1, 18'd4), 32'd0, 32'h0000_00F1, 32'd0);
      issue(32'hCFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'h9ABC_DEF0);
      issue(enc(4'h4, 5'd12, 5'd3, 18'h1FFFF), 32'd0, 32'd1, 32'd0);
      @(negedge clk);
      chk_w("addiu_max_imm", 128'(bus.result_o), 128'(32'h0002_0000));
      step();

      // Backpressure across three ADDUs
      bus.out_ready_i = 1'b0;
      issue(enc(4'h3, 5'd1, 5'd1, 18'd0), 32'd0, 32'd1, 32'd2);
      drive(enc(4'h3, 5'd2, 5'd1, 18'd0), 32'd0, 32'd10, 32'd20);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk_b("stall_in_ready", bus.in_ready_o, 1'b0);
         chk_w("stall_record", 128'({bus.out_valid_o, bus.result_o, bus.writenum_o}),
               128'({1'b1, 32'd3, 6'h21}));
         step();
      end
      bus.out_ready_i = 1'b1;
      wait_accept();
      issue(enc(4'h3, 5'd3, 5'd1, 18'd0), 32'd0, 32'd100, 32'd200);
      repeat (3) step();

      // Taken BGE on equal operands while the record stalls
      bus.out_ready_i = 1'b0;
      issue(enc(4'h7, 5'd0, 5'd1, 18'h3FFF0), 32'h40, 32'h8000_0000, 32'h8000_0000);
      @(negedge clk);
      chk_w("bge_pulse", 128'({bus.br_taken_o, bus.br_target_o, bus.writenum_o}),
            128'({1'b1, 32'h30, 6'd0}));
      step();
      @(negedge clk);
      chk_w("bge_no_repulse", 128'({bus.out_valid_o, bus.br_taken_o}), 128'({1'b1, 1'b0}));
      step();
      bus.out_ready_i = 1'b1;
      issue(enc(4'h7, 5'd0, 5'd1, 18'h3FFF0), 32'h40, 32'hFFFF_FFFF, 32'd0);
      @(negedge clk);
      chk_w("bge_not_taken", 128'({bus.out_valid_o, bus.br_taken_o, bus.writenum_o}),
            128'({1'b1, 1'b0, 6'd0}));
      step();
      issue({4'h8, 28'h0AB_CDEF}, 32'h1234_5678, 32'd0, 32'd0);
      @(negedge clk);
      chk_w("j_pulse", 128'({bus.br_taken_o, bus.br_target_o}), 128'({1'b1, 32'h10AB_CDEF}));
      step();

      // Reset in the middle of a MUL
      issue(enc(4'h6, 5'd13, 5'd1, 18'd0), 32'd0, 32'd5, 32'd6);
      repeat (9) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk_w("mid_mul_reset",
            128'({bus.out_valid_o, bus.in_ready_o, bus.result_o, bus.store_o, bus.writenum_o,
                  bus.mem_rd_o, bus.mem_wr_o, bus.br_taken_o, bus.br_target_o}), 128'd0);
      repeat (2) step();
      rst_n = 1'b1;
      @(negedge clk);
      chk_b("post_mul_reset_ready", bus.in_ready_o, 1'b1);
      repeat (40) step();
      @(negedge clk);
      chk_b("no_stale_record", bus.out_valid_o, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the MS108 CPU pipeline, directly downstream of the register file. Accepts a decoded instruction word with its two register-file operands, performs the ALU, shift, multiply, compare and address computation, and emits one result record per instruction toward memory/writeback. The record's `writenum_o` uses the register-file write-port encoding, so it feeds the register file's write port after memory/writeback. Multiply is a multi-cycle shift-add unit; all other operations take a single cycle.

## Interface
Parameters:
- `MUL_CYCLES`, 32: iterations of the shift-add multiplier. One multiplier bit is consumed per cycle.

Ports:
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `in_valid_i`  in  1  upstream holds an instruction.
- `in_ready_o`  out  1  stage can accept this cycle.
- `IR_i`  in  32  instruction. Fields: op=[31:28], ra=[27:23], rs=[22:18], rt=[17:13], imm18=[17:0].
- `pc_i`  in  32  word address of the instruction.
- `data1_i`  in  32  value of reg[rs].
- `data2_i`  in  32  value of reg[rt] for ADDU/MUL; value of reg[ra] for all other opcodes.
- `out_valid_o`  out  1  result record valid.
- `out_ready_i`  in  1  downstream accepts the record.
- `result_o`  out  32  ALU result or memory address.
- `store_o`  out  32  store data for SW.
- `writenum_o`  out  6  bit5 is the write enable; [4:0] is the destination register.
- `mem_rd_o`, `mem_wr_o`  out  1 each  LW/SW flags.
- `br_taken_o`  out  1  one-cycle redirect pulse.
- `br_target_o`  out  32  redirect address; valid while `br_taken_o` is high.

## Operation
Ops, with sx = sign-extend to 32 bits:
- LW 0000: result=data1+sx(imm18); mem_rd=1; writenum={1,ra}.
- SW 0001: result=data1+sx(imm18); store=data2; mem_wr=1; writenum=0.
- LI 0010: result=sx(IR[22:0]); writenum={1,ra}.
- ADDU 0011: result=data1+data2, mod 2^32; writenum={1,ra}.
- ADDIU 0100: result=data1+sx(imm18); writenum={1,ra}.
- SLL 0101: result=data1<<IR[4:0]; writenum={1,ra}.
- MUL 0110: result=low 32 bits of data1*data2; writenum={1,ra}.
- MULI 1001: result=low 32 bits of data1*sx(imm18); writenum={1,ra}.
- BGE 0111: signed compare data1>=data2. If true, pulse br_taken with target=pc_i+sx(imm18). writenum=0.
- J 1000: always taken; target={pc_i[31:28],IR[27:0]}; writenum=0.
- 1010-1111: NOP record with all fields 0.

Record and state-machine rules:
- Every accepted instruction produces exactly one record, including branches and NOPs.
- Acceptance is the cycle with `in_valid_i && in_ready_o`.
- State machine states: IDLE, MUL, OUT.
  - IDLE→OUT on a single-cycle op.
  - IDLE→MUL on MUL/MULI. The stage latches the multiplicand and multiplier and clears the accumulator and counter.
  - MUL stays for MUL_CYCLES cycles. Each cycle: if multiplier[0], acc+=mcand; mcand<<=1; multiplier>>=1. All arithmetic is 32-bit and wraps. On the final iteration the state goes to OUT.
  - OUT→IDLE when out_ready_i is high. OUT→OUT (a new single-cycle op) or OUT→MUL when out_ready_i is high and a new instruction is accepted in the same cycle.
- `in_ready_o` = (state==IDLE) || (state==OUT && out_ready_i). It is combinational and low throughout MUL.

## Timing
- Reset: state=IDLE, counter=0, and all outputs 0 (`in_ready_o` becomes 1 once reset is released). Reset asserted mid-MUL or mid-OUT discards the instruction; no record is emitted.
- Single-cycle op accepted in cycle T: record visible from T+1 and held stable until out_ready_i is high.
- MUL/MULI accepted in cycle T: iterations run in T+1..T+MUL_CYCLES; record visible from T+MUL_CYCLES+1 (T+33 by default).
- Branch pulse: br_taken_o is high only in T+1 for a taken BGE/J accepted at T, independent of out_ready_i. It is never re-asserted while the record stalls.
- Back-to-back: one single-cycle op per cycle when out_ready_i is held high.
- Record fields do not change while out_valid_o=1 and out_ready_i=0.

## Test plan
- ADDU with data1=0xFFFFFFFF, data2=2, ra=5 -> result=1, writenum=0x25, out_valid in T+1.
- ADDIU with data1=10, imm18=0x3FFFF -> result=9; LW with data1=0x100, imm18=4 -> result=0x104, mem_rd=1, writenum={1,ra}.
- MUL with data1=7, data2=0xFFFFFFFD -> result=0xFFFFFFEB in T+33; in_ready_o=0 during T+1..T+32; a second MUL accepted in the same cycle the record is consumed also completes 33 cycles later.
- Backpressure: three ADDUs with out_ready_i=0 for 4 cycles -> first record held stable, in_ready_o=0, no record lost or duplicated after release.
- BGE with data1=data2=0x80000000, pc=0x40, imm18=0x3FFF0 -> br_taken_o is a single pulse with br_target=0x30; with data1=-1, data2=0 -> no pulse; both produce records with writenum=0.
- Reset asserted at T+10 of a MUL -> all outputs 0 at once; after release, in_ready_o=1 and no stale record appears.
